// File: rtl/output_port_arbiter_pkg.sv
// Shared types and constants for the router output-port arbiter.
//   FLIT_WIDTH  : width of a flit on the port mux (head/body/tail flits)
//   NUM_PORTS   : router input ports competing for one output port
//   arb_state_t : arbiter FSM state (idle / locked to a packet)
//   port_idx_t  : index of an input port, also the mux select encoding
//   next_idx    : round-robin successor of a port index (wraps 3 -> 0)
package output_port_arbiter_pkg;

  localparam int unsigned FLIT_WIDTH = 17;
  localparam int unsigned NUM_PORTS  = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef logic [1:0] port_idx_t;

  function automatic port_idx_t next_idx(port_idx_t p);
    return p + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the input buffers / downstream link and one output-port arbiter.
//   req_i       : per-input "holds a flit for this port"
//   tail_i      : per-input "current flit is a tail"
//   out_ready_i : downstream can accept a flit this cycle
//   grant_o     : one-hot pop strobe back to the inputs
//   sel_o       : mux_4_1 select (registered owner)
//   valid_o     : flit on the mux output is valid
//   busy_o      : port locked to a packet
// Modports: master drives requests and observes grants; slave is the arbiter.
interface output_port_arbiter_if;
  import output_port_arbiter_pkg::*;

  logic [NUM_PORTS-1:0] req_i;
  logic [NUM_PORTS-1:0] tail_i;
  logic                 out_ready_i;
  logic [NUM_PORTS-1:0] grant_o;
  port_idx_t            sel_o;
  logic                 valid_o;
  logic                 busy_o;

  modport master (
    output req_i,
    output tail_i,
    output out_ready_i,
    input  grant_o,
    input  sel_o,
    input  valid_o,
    input  busy_o
  );

  modport slave (
    input  req_i,
    input  tail_i,
    input  out_ready_i,
    output grant_o,
    output sel_o,
    output valid_o,
    output busy_o
  );

endinterface

// File: rtl/output_port_arbiter_rr_priority_pick.sv
// Combinational round-robin priority pick.
//   req   : request vector, one bit per input port
//   ptr   : highest-priority index this round
//   found : at least one request is set
//   idx   : first set request at or after ptr, wrapping past the top index
module output_port_arbiter_rr_priority_pick
  import output_port_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output logic                 found,
  output port_idx_t            idx
);

  port_idx_t cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    // 2-bit addition gives the modulo-4 wrap for free.
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      cand = ptr + port_idx_t'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole round-robin arbiter for one router output port.
// Shares the port's 4:1 flit mux among the four input ports: once a packet wins,
// the port stays locked to its input until that input's tail flit is transferred.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high; abandons any lock in progress
//   arb   : slave side of output_port_arbiter_if (req/tail/ready in, grant/sel/valid/busy out)
// sel_o is the owner register, so there is no combinational path from req_i to sel_o.
// grant_o/valid_o/busy_o are combinational from state, owner and inputs.
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_PORTS,
  parameter int unsigned SEL_WIDTH = $clog2(NUM_REQ)
) (
  input logic                   clk,
  input logic                   reset,
  output_port_arbiter_if.slave  arb
);

  // The datapath mux is a fixed 4:1, so anything else is a build error.
  if (NUM_REQ != 4) begin : g_bad_num_req
    $error("output_port_arbiter: NUM_REQ must be 4");
  end
  if (SEL_WIDTH != 2) begin : g_bad_sel_width
    $error("output_port_arbiter: SEL_WIDTH must be 2");
  end

  arb_state_t state_q;
  port_idx_t  owner_q;
  port_idx_t  rr_ptr_q;

  logic       pick_found;
  port_idx_t  pick_idx;
  logic       xfer;

  output_port_arbiter_rr_priority_pick u_pick (
    .req   (arb.req_i),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A flit moves only when locked, the owner has one and downstream is ready.
  // Gating with reset keeps the reset cycle grant-free even if we were locked.
  assign xfer = (state_q == ARB_LOCKED) && !reset && arb.req_i[owner_q] && arb.out_ready_i;

  always_comb begin
    arb.grant_o = '0;
    if (xfer) begin
      arb.grant_o[owner_q] = 1'b1;
    end
  end

  assign arb.valid_o = xfer;
  assign arb.busy_o  = (state_q == ARB_LOCKED) && !reset;
  assign arb.sel_o   = owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            state_q <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          // Owner stalls (req low or no ready) simply hold the lock.
          if (xfer && arb.tail_i[owner_q]) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= next_idx(owner_q);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: each step drives one cycle of inputs
// and checks that cycle's grant/sel/busy/valid against hand-computed values.
module tb_output_port_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  output_port_arbiter_if bus ();

  output_port_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs, check outputs mid-cycle, then advance past the edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] t, input logic rd,
                     input logic [3:0] eg, input logic [1:0] es, input logic eb,
                     input string tag);
    bus.req_i       = r;
    bus.tail_i      = t;
    bus.out_ready_i = rd;
    #1;
    check({tag, ".grant"}, bus.grant_o, eg);
    check({tag, ".sel"},   {2'b00, bus.sel_o}, {2'b00, es});
    check({tag, ".busy"},  {3'b000, bus.busy_o}, {3'b000, eb});
    check({tag, ".valid"}, {3'b000, bus.valid_o}, {3'b000, |eg});
    check({tag, ".onehot"}, {3'b000, $onehot0(bus.grant_o)}, 4'b0001);
    tick();
  endtask

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    reset           = 1'b1;
    bus.req_i       = 4'hF;
    bus.tail_i      = 4'h0;
    bus.out_ready_i = 1'b1;
    tick();

    // Reset with all inputs requesting: nothing granted, port free.
    cyc(4'hF, 4'h0, 1'b1, 4'b0000, 2'd0, 1'b0, "reset");
    reset = 1'b0;

    // Arbitration cycle, then owner 0 sends three flits, tail on the last.
    cyc(4'hF, 4'h0, 1'b1, 4'b0000, 2'd0, 1'b0, "arb0");
    cyc(4'hF, 4'h0, 1'b1, 4'b0001, 2'd0, 1'b1, "p0_f1");
    cyc(4'hF, 4'h0, 1'b1, 4'b0001, 2'd0, 1'b1, "p0_f2");
    cyc(4'hF, 4'h1, 1'b1, 4'b0001, 2'd0, 1'b1, "p0_tail");
    // rr_ptr is now 1, so input 1 wins next.
    cyc(4'hF, 4'h0, 1'b1, 4'b0000, 2'd0, 1'b0, "arb1");

    // Fairness: everyone sends single-flit packets, one bubble between grants.
    cyc(4'hF, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, "rr_g1");
    cyc(4'hF, 4'hF, 1'b1, 4'b0000, 2'd1, 1'b0, "rr_b1");
    cyc(4'hF, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, "rr_g2");
    cyc(4'hF, 4'hF, 1'b1, 4'b0000, 2'd2, 1'b0, "rr_b2");
    cyc(4'hF, 4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, "rr_g3");
    cyc(4'hF, 4'hF, 1'b1, 4'b0000, 2'd3, 1'b0, "rr_b3");
    cyc(4'hF, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, "rr_g0");
    cyc(4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, "rr_b0");
    cyc(4'hF, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, "rr_g1b");

    // Backpressure mid-packet on owner 2.
    cyc(4'hF, 4'h0, 1'b1, 4'b0000, 2'd1, 1'b0, "arb2");
    cyc(4'hF, 4'h0, 1'b1, 4'b0100, 2'd2, 1'b1, "bp_f1");
    for (int i = 0; i < 5; i++) begin
      cyc(4'hF, 4'h0, 1'b0, 4'b0000, 2'd2, 1'b1, "bp_stall");
    end
    cyc(4'hF, 4'h0, 1'b1, 4'b0100, 2'd2, 1'b1, "bp_f2");

    // Owner 2 drops its request while input 3 waits: lock holds.
    for (int i = 0; i < 3; i++) begin
      cyc(4'h8, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b1, "drop_hold");
    end
    cyc(4'hC, 4'h0, 1'b1, 4'b0100, 2'd2, 1'b1, "drop_f3");
    cyc(4'hC, 4'h4, 1'b1, 4'b0100, 2'd2, 1'b1, "drop_tail");

    // Wrap-around: rr_ptr=3, req=1001 -> 3 wins, then pointer wraps to 0.
    cyc(4'h9, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b0, "arb3");
    cyc(4'h9, 4'h0, 1'b1, 4'b1000, 2'd3, 1'b1, "w3_f1");
    cyc(4'h9, 4'h8, 1'b1, 4'b1000, 2'd3, 1'b1, "w3_tail");
    cyc(4'h9, 4'h0, 1'b1, 4'b0000, 2'd3, 1'b0, "arb0w");
    cyc(4'h9, 4'h1, 1'b1, 4'b0001, 2'd0, 1'b1, "w0_tail");

    // rr_ptr=1: scan 1,2,3 -> 3 wins; then reset while locked.
    cyc(4'h9, 4'h0, 1'b1, 4'b0000, 2'd0, 1'b0, "arb3b");
    cyc(4'h9, 4'h0, 1'b1, 4'b1000, 2'd3, 1'b1, "l3_f1");
    reset = 1'b1;
    cyc(4'h9, 4'h0, 1'b1, 4'b0000, 2'd3, 1'b0, "rst_locked");
    reset = 1'b0;
    // Back to IDLE with owner 0 and rr_ptr 0, so input 0 wins over 3.
    cyc(4'h9, 4'h0, 1'b1, 4'b0000, 2'd0, 1'b0, "post_rst");
    cyc(4'h9, 4'h1, 1'b1, 4'b0001, 2'd0, 1'b1, "post_rst_g0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
